// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and helpers for the round-robin arbitrating mux
package mux_pkg;

    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

    // Index width for n channels, never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - one-hot grant generator with round-robin pointer or fixed priority
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N    = 4,
    parameter int MODE = MODE_RR,
    localparam int IW  = idx_width(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_cand;
    logic          w_found;

    // Walk candidates in priority order; the first requester wins.
    // Round-robin starts just after the last winner, fixed starts at 0.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_cand    = '0;
        for (int k = 0; k < N; k++) begin
            if (MODE == MODE_FIXED) begin
                w_cand = IW'(k);
            end else begin
                w_cand = IW'((int'(r_ptr) + 1 + k) % N);
            end
            if (!w_found && req[w_cand]) begin
                w_found          = 1'b1;
                grant[w_cand]    = 1'b1;
                grant_idx        = w_cand;
            end
        end
    end

    // Pointer moves to the winner only when its word is actually taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= IW'(N - 1);
        end else if (MODE == MODE_RR && advance && w_found) begin
            r_ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// rtl/rr_arb_mux.sv - N-channel arbitrating mux with a single registered output stage
module rr_arb_mux
    import mux_pkg::*;
#(
    parameter int W    = 4,
    parameter int N    = 4,
    parameter int MODE = MODE_RR,
    localparam int SW  = idx_width(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_sel,
    input  logic           out_ready
);

    logic           w_load;
    logic [N-1:0]   w_grant;
    logic [SW-1:0]  w_grant_idx;
    logic [W-1:0]   w_sel_data;
    logic           r_out_valid;
    logic [W-1:0]   r_out_data;
    logic [SW-1:0]  r_out_sel;

    // The output stage can take a word when empty or when it drains this cycle
    assign w_load = !r_out_valid || out_ready;

    rr_arbiter #(
        .N    (N),
        .MODE (MODE)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (in_valid),
        .advance   (w_load),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    assign in_ready = (rst_n && w_load) ? w_grant : '0;

    // One-hot AND-OR select so unselected channels, X or not, never leak through
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant[i]) begin
                w_sel_data = in_data[i*W +: W];
            end
        end
    end

    // Output register: refill on load, empty when nothing is offered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
        end else if (w_load) begin
            if (|w_grant) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sel_data;
                r_out_sel   <= w_grant_idx;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb/tb_rr_arb_mux.sv - self-checking bench for rr_arb_mux in both arbitration modes
module tb_rr_arb_mux;

    localparam int W = 4;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic           out_ready;

    logic [N-1:0]   rr_in_ready, fx_in_ready;
    logic           rr_out_valid, fx_out_valid;
    logic [W-1:0]   rr_out_data, fx_out_data;
    logic [1:0]     rr_out_sel, fx_out_sel;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state, index 0 = round-robin, 1 = fixed priority
    bit             m_v[2];
    logic [W-1:0]   m_d[2];
    int             m_s[2];
    int             m_ptr[2];

    typedef struct {
        logic [N-1:0]   v;
        logic [N*W-1:0] d;
        bit             rdy;
        int             es;
        logic [W-1:0]   ed;
    } vec_t;

    vec_t tbl[5];

    always #5 clk = ~clk;

    rr_arb_mux #(.W(W), .N(N), .MODE(0)) dut_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (rr_in_ready),
        .out_valid (rr_out_valid),
        .out_data  (rr_out_data),
        .out_sel   (rr_out_sel),
        .out_ready (out_ready)
    );

    rr_arb_mux #(.W(W), .N(N), .MODE(1)) dut_fx (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (fx_in_ready),
        .out_valid (fx_out_valid),
        .out_data  (fx_out_data),
        .out_sel   (fx_out_sel),
        .out_ready (out_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Winner chosen straight from the rules: rotate from ptr+1, or lowest index
    function automatic int pick(input int mode, input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (mode == 1) ? k : (ptr + 1 + k) % N;
            if (v[j] === 1'b1) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_v[m] = 1'b0; m_d[m] = '0; m_s[m] = 0; m_ptr[m] = N - 1;
        end
    endtask

    // One clock: inputs already set after a falling edge
    task automatic cycle();
        int           g[2];
        bit           ld[2];
        logic [N-1:0] er;
        logic [W-1:0] nd[2];
        #1;
        for (int m = 0; m < 2; m++) begin
            ld[m] = !m_v[m] || out_ready;
            g[m]  = pick(m, in_valid, m_ptr[m]);
            er    = (ld[m] && g[m] >= 0) ? N'(1 << g[m]) : '0;
            nd[m] = (g[m] >= 0) ? in_data[g[m]*W +: W] : '0;
            chk(m == 0 ? "rr_in_ready" : "fx_in_ready", m == 0 ? rr_in_ready : fx_in_ready, er);
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (ld[m]) begin
                if (g[m] >= 0) begin
                    m_v[m] = 1'b1; m_d[m] = nd[m]; m_s[m] = g[m];
                    if (m == 0) m_ptr[m] = g[m];
                end else begin
                    m_v[m] = 1'b0;
                end
            end
        end
        #1;
        chk("rr_out_valid", rr_out_valid, m_v[0]);
        chk("rr_out_sel",   rr_out_sel,   m_s[0]);
        chk("rr_out_data",  rr_out_data,  m_d[0]);
        chk("fx_out_valid", fx_out_valid, m_v[1]);
        chk("fx_out_sel",   fx_out_sel,   m_s[1]);
        chk("fx_out_data",  fx_out_data,  m_d[1]);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = '0; out_ready = 1'b1;
        model_reset();
        #1;
        chk("rst_out_valid", rr_out_valid, 0);
        chk("rst_out_data",  rr_out_data,  0);
        chk("rst_out_sel",   rr_out_sel,   0);
        chk("rst_in_ready",  rr_in_ready | fx_in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b1;
        model_reset();

        tbl[0] = '{4'b1111, 16'hDCBA, 1'b1, 0, 4'hA};
        tbl[1] = '{4'b1111, 16'hDCBA, 1'b1, 1, 4'hB};
        tbl[2] = '{4'b1111, 16'hDCBA, 1'b1, 2, 4'hC};
        tbl[3] = '{4'b1111, 16'hDCBA, 1'b1, 3, 4'hD};
        tbl[4] = '{4'b1111, 16'hDCBA, 1'b1, 0, 4'hA};

        // Case 1: full round-robin rotation, continuous throughput
        do_reset();
        for (int i = 0; i < 5; i++) begin
            in_valid = tbl[i].v; in_data = tbl[i].d; out_ready = tbl[i].rdy;
            cycle();
            chk("c1_valid", rr_out_valid, 1);
            chk("c1_sel",   rr_out_sel,   tbl[i].es);
            chk("c1_data",  rr_out_data,  tbl[i].ed);
        end

        // Case 2: backpressure with channel 2's word held
        do_reset();
        in_valid = 4'b1111; in_data = 16'hDCBA; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("c2_hold_sel",  rr_out_sel,  2);
            chk("c2_hold_data", rr_out_data, 4'hC);
            chk("c2_in_ready",  rr_in_ready, 0);
        end
        out_ready = 1'b1;
        cycle();
        chk("c2_next_sel", rr_out_sel, 3);

        // Case 3: fixed priority, lowest index wins
        do_reset();
        in_valid = 4'b1010; in_data = 16'hDCBA; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("c3_sel_lo", fx_out_sel, 1);
        end
        in_valid = 4'b1000;
        cycle();
        chk("c3_sel_hi", fx_out_sel, 3);

        // Case 4: unknown data on channel 3 only
        do_reset();
        in_valid = 4'b1111; in_data = {4'bxxxx, 4'd3, 4'd10, 4'd7}; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("c4_noX", 32'($isunknown(rr_out_data)), 0);
        end
        cycle();
        chk("c4_sel3",  rr_out_sel, 3);
        chk("c4_copy3", rr_out_data, in_data[15:12]);
        in_data = 16'hDCBA;

        // Case 5: reset pulse while a word is stalled
        do_reset();
        in_valid = 4'b1111; out_ready = 1'b0;
        cycle();
        chk("c5_held", rr_out_valid, 1);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        chk("c5_rst_valid", rr_out_valid, 0);
        chk("c5_rst_ready", rr_in_ready, 0);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        cycle();
        chk("c5_first_sel", rr_out_sel, 0);

        // Case 6: single sparse request then idle
        do_reset();
        in_valid = 4'b0100; out_ready = 1'b1;
        cycle();
        chk("c6_valid", rr_out_valid, 1);
        chk("c6_sel",   rr_out_sel,   2);
        in_valid = 4'b0000;
        cycle();
        chk("c6_idle", rr_out_valid, 0);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            in_valid  = N'($urandom);
            in_data   = (N*W)'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
